// File: rtl/cn_reg_pkg.sv
// Shared constants for the cn_reg register slave: word address map,
// CTRL/STATUS bit positions and the control FSM state type.
package cn_reg_pkg;

  localparam int unsigned ADDR_AX0    = 0;
  localparam int unsigned ADDR_BX0    = 4;
  localparam int unsigned ADDR_BX1    = 8;
  localparam int unsigned ADDR_CTRL   = 12;
  localparam int unsigned ADDR_STATUS = 13;
  localparam int unsigned ADDR_CYCLES = 14;

  // ax0, bx0 and bx1 occupy words 0..11 contiguously
  localparam int unsigned SEED_WORDS  = 12;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_CLEAR_BIT = 1;

  localparam int STS_BUSY_BIT = 0;
  localparam int STS_DONE_BIT = 1;
  localparam int STS_ERR_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } cn_state_e;

endpackage

// File: rtl/cn_reg_ctrl_fsm.sv
// Run-control FSM for the core: start pulse, busy/done tracking, sticky
// error flag for host writes that arrive while the core is running.
// Optional BUSY-cycle counter enabled by CN_REG_CYCLE_CNT_EN.
module cn_reg_ctrl_fsm
  import cn_reg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        ctrl_wr,     // host write to CTRL
  input  logic        ctrl_start,  // CTRL bit0 of that write
  input  logic        ctrl_clear,  // CTRL bit1 of that write
  input  logic        seed_wr,     // host write to any seed word
  input  logic        ml_finished,
  output logic        ml_start,
  output logic        sts_busy,
  output logic        sts_done,
  output logic        sts_err,
  output logic [31:0] cycle_cnt
);

  cn_state_e state_q, state_d;
  logic      err_q, err_d;

  // State and sticky error registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  // Next state, error update and decoded outputs
  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    ml_start = 1'b0;
    sts_busy = 1'b0;
    sts_done = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ctrl_wr && ctrl_start) state_d = ST_START;
      end
      ST_START: begin
        ml_start = 1'b1;
        sts_busy = 1'b1;
        state_d  = ST_BUSY;
      end
      ST_BUSY: begin
        sts_busy = 1'b1;
        if (ml_finished) state_d = ST_DONE;
      end
      ST_DONE: begin
        sts_done = 1'b1;
        if (ctrl_wr && ctrl_start)      state_d = ST_START;
        else if (ctrl_wr && ctrl_clear) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A rejected write while running sets ERR; that wins over a clear
    // carried in the same CTRL write.
    if (sts_busy && (seed_wr || (ctrl_wr && ctrl_start))) err_d = 1'b1;
    else if (ctrl_wr && ctrl_clear)                        err_d = 1'b0;
  end

  assign sts_err = err_q;

`ifdef CN_REG_CYCLE_CNT_EN
  logic [31:0] cnt_q;

  // Count BUSY cycles of the current run; restart on entry to START, saturate
  always_ff @(posedge clk) begin
    if (reset)                                    cnt_q <= '0;
    else if (state_d == ST_START && state_q != ST_START) cnt_q <= '0;
    else if (state_q == ST_BUSY && cnt_q != '1)   cnt_q <= cnt_q + 32'd1;
  end

  assign cycle_cnt = cnt_q;
`else
  assign cycle_cnt = '0;
`endif

endmodule

// File: rtl/cn_reg_slave.sv
// Host register slave for the core: 12 seed words (ax0/bx0/bx1), CTRL,
// STATUS and an optional BUSY-cycle count word. Reads are registered and
// return pre-write data when read and write hit the same address.
// Optional feature macro: CN_REG_CYCLE_CNT_EN (address 14 cycle count).
module cn_reg_slave
  import cn_reg_pkg::*;
#(
  parameter int REG_AW = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] reg_address,
  input  logic              reg_write,
  input  logic              reg_read,
  input  logic [31:0]       reg_wrdata,
  output logic [31:0]       reg_rddata,
  output logic [127:0]      ax0,
  output logic [127:0]      bx0,
  output logic [127:0]      bx1,
  output logic              ml_start,
  input  logic              ml_finished,
  output logic              sts_busy
);

  logic [SEED_WORDS-1:0][31:0] seed_q;
  logic                        in_seed;
  logic                        is_ctrl;
  logic                        sts_done;
  logic                        sts_err;
  logic [31:0]                 cycle_cnt;
  logic [31:0]                 status;
  logic [31:0]                 rd_mux;

  assign in_seed = (reg_address < REG_AW'(SEED_WORDS));
  assign is_ctrl = (reg_address == REG_AW'(ADDR_CTRL));

  assign ax0 = seed_q[ADDR_AX0+3:ADDR_AX0];
  assign bx0 = seed_q[ADDR_BX0+3:ADDR_BX0];
  assign bx1 = seed_q[ADDR_BX1+3:ADDR_BX1];

  cn_reg_ctrl_fsm u_fsm (
    .clk         (clk),
    .reset       (reset),
    .ctrl_wr     (reg_write && is_ctrl),
    .ctrl_start  (reg_wrdata[CTRL_START_BIT]),
    .ctrl_clear  (reg_wrdata[CTRL_CLEAR_BIT]),
    .seed_wr     (reg_write && in_seed),
    .ml_finished (ml_finished),
    .ml_start    (ml_start),
    .sts_busy    (sts_busy),
    .sts_done    (sts_done),
    .sts_err     (sts_err),
    .cycle_cnt   (cycle_cnt)
  );

  // Seed words; writes are dropped while the core is running
  always_ff @(posedge clk) begin
    if (reset)                                  seed_q <= '0;
    else if (reg_write && in_seed && !sts_busy) seed_q[reg_address[3:0]] <= reg_wrdata;
  end

  // STATUS word assembly
  always_comb begin
    status               = '0;
    status[STS_BUSY_BIT] = sts_busy;
    status[STS_DONE_BIT] = sts_done;
    status[STS_ERR_BIT]  = sts_err;
  end

  // Read mux; CTRL and unmapped addresses read as zero
  always_comb begin
    rd_mux = '0;
    if (in_seed)                                     rd_mux = seed_q[reg_address[3:0]];
    else if (reg_address == REG_AW'(ADDR_STATUS))    rd_mux = status;
    else if (reg_address == REG_AW'(ADDR_CYCLES))    rd_mux = cycle_cnt;
  end

  // Registered read data, held between reads
  always_ff @(posedge clk) begin
    if (reset)         reg_rddata <= '0;
    else if (reg_read) reg_rddata <= rd_mux;
  end

endmodule

// File: tb/tb_cn_reg_slave.sv
// Self-checking bench for cn_reg_slave: directed vector table, hand-written
// run/abort sequences and randomized traffic against a behavioural model.
module tb_cn_reg_slave;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [7:0]   reg_address = '0;
  logic         reg_write = 1'b0;
  logic         reg_read = 1'b0;
  logic [31:0]  reg_wrdata = '0;
  logic [31:0]  reg_rddata;
  logic [127:0] ax0, bx0, bx1;
  logic         ml_start;
  logic         ml_finished = 1'b0;
  logic         sts_busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cn_reg_slave #(.REG_AW(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .reg_address (reg_address),
    .reg_write   (reg_write),
    .reg_read    (reg_read),
    .reg_wrdata  (reg_wrdata),
    .reg_rddata  (reg_rddata),
    .ax0         (ax0),
    .bx0         (bx0),
    .bx1         (bx1),
    .ml_start    (ml_start),
    .ml_finished (ml_finished),
    .sts_busy    (sts_busy)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    reg_address = a; reg_wrdata = d; reg_write = 1'b1;
    tick();
    reg_write = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    reg_address = a; reg_read = 1'b1;
    tick();
    reg_read = 1'b0;
    d = reg_rddata;
  endtask

  task automatic pulse_finished();
    ml_finished = 1'b1;
    tick();
    ml_finished = 1'b0;
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_words [12];
  bit          m_starting, m_running, m_done, m_err;
  logic [31:0] m_cycles, m_rd;

  task automatic model_reset();
    for (int i = 0; i < 12; i++) m_words[i] = '0;
    m_starting = 0; m_running = 0; m_done = 0; m_err = 0;
    m_cycles = '0; m_rd = '0;
  endtask

  function automatic logic [31:0] model_read(input int a);
    if (a < 12)  return m_words[a];
    if (a == 13) return {29'd0, m_err, m_done, (m_starting || m_running)};
`ifdef CN_REG_CYCLE_CNT_EN
    if (a == 14) return m_cycles;
`endif
    return '0;
  endfunction

  task automatic model_step(input bit w, input bit r, input int a, input logic [31:0] d, input bit fin);
    bit running_now;
    bit ctrl_w;
    running_now = m_starting || m_running;
    ctrl_w = w && (a == 12);
    if (r) m_rd = model_read(a);
    if (running_now && w && (a < 12 || (ctrl_w && d[0]))) m_err = 1;
    else if (ctrl_w && d[1])                               m_err = 0;
    if (w && a < 12 && !running_now) m_words[a] = d;
    if (m_starting) begin
      m_starting = 0; m_running = 1;
    end else if (m_running) begin
      if (m_cycles != 32'hFFFF_FFFF) m_cycles++;
      if (fin) begin m_running = 0; m_done = 1; end
    end else if (ctrl_w && d[0]) begin
      m_starting = 1; m_done = 0; m_cycles = '0;
    end else if (ctrl_w && d[1]) begin
      m_done = 0;
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit          is_wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt [10];

  initial begin
    logic [31:0]  rv;
    logic [127:0] saved;
    int           starts;
    int           a;
    bit           w, r, f;
    logic [31:0]  d;

    vt[0] = '{1'b1, 8'd0,   32'h6183_3732, 32'h0};
    vt[1] = '{1'b1, 8'd1,   32'h8862_2535, 32'h0};
    vt[2] = '{1'b0, 8'd0,   32'h0,         32'h6183_3732};
    vt[3] = '{1'b0, 8'd1,   32'h0,         32'h8862_2535};
    vt[4] = '{1'b1, 8'd11,  32'hA5A5_0011, 32'h0};
    vt[5] = '{1'b0, 8'd11,  32'h0,         32'hA5A5_0011};
    vt[6] = '{1'b1, 8'd13,  32'hFFFF_FFFF, 32'h0};
    vt[7] = '{1'b0, 8'd13,  32'h0,         32'h0};
    vt[8] = '{1'b0, 8'd200, 32'h0,         32'h0};
    vt[9] = '{1'b0, 8'd12,  32'h0,         32'h0};

    // Reset state
    tick(); tick();
    reset = 1'b0;
    check("rst_ax0", ax0, '0);
    check("rst_bx0", bx0, '0);
    check("rst_bx1", bx1, '0);
    check("rst_rddata", {96'd0, reg_rddata}, '0);
    check("rst_ml_start", {127'd0, ml_start}, '0);
    check("rst_busy", {127'd0, sts_busy}, '0);

    for (int i = 0; i < 10; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
      else begin
        rd(vt[i].addr, rv);
        check($sformatf("vec%0d_rd", i), {96'd0, rv}, {96'd0, vt[i].exp});
      end
    end
    check("ax0_low64", {64'd0, ax0[63:0]}, {64'd0, 64'h8862_2535_6183_3732});
    check("status_write_no_err", {127'd0, sts_busy}, '0);

    // Start pulse, busy status, completion
    starts = 0;
    wr(8'd12, 32'h1);
    check("start_pulse", {127'd0, ml_start}, 128'd1);
    check("start_busy", {127'd0, sts_busy}, 128'd1);
    starts += ml_start;
    for (int i = 0; i < 4; i++) begin
      rd(8'd13, rv);
      starts += ml_start;
      check("sts_running", {96'd0, rv}, 128'h1);
    end
    check("single_start", 128'(starts), 128'd1);
    pulse_finished();
    rd(8'd13, rv);
    check("sts_done", {96'd0, rv}, 128'h2);

    // Seed write rejected while running
    wr(8'd12, 32'h1);
    tick();
    saved = bx0;
    wr(8'd5, 32'hDEAD_BEEF);
    check("bx0_locked", bx0, saved);
    rd(8'd13, rv);
    check("sts_busy_err", {96'd0, rv}, 128'h5);
    pulse_finished();
    rd(8'd13, rv);
    check("sts_done_err", {96'd0, rv}, 128'h6);
    wr(8'd12, 32'h2);
    rd(8'd13, rv);
    check("sts_cleared", {96'd0, rv}, 128'h0);

    // Reset mid-run abandons it
    wr(8'd12, 32'h1);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_ax0", ax0, '0);
    check("abort_bx0", bx0, '0);
    check("abort_bx1", bx1, '0);
    check("abort_rddata", {96'd0, reg_rddata}, '0);
    check("abort_outs", {126'd0, ml_start, sts_busy}, '0);
    pulse_finished();
    starts = 0;
    for (int i = 0; i < 5; i++) begin tick(); starts += ml_start; end
    check("abort_no_start", 128'(starts), '0);
    rd(8'd13, rv);
    check("abort_status", {96'd0, rv}, '0);

    // BUSY cycle count: finish 100 cycles after the start pulse
    wr(8'd12, 32'h1);
    repeat (100) tick();
    pulse_finished();
    rd(8'd14, rv);
`ifdef CN_REG_CYCLE_CNT_EN
    check("cycles_100", {96'd0, rv}, 128'd100);
`else
    check("cycles_off", {96'd0, rv}, 128'd0);
`endif
    wr(8'd12, 32'h2);

    // Same-cycle read and write returns the old value
    reg_address = 8'd8; reg_wrdata = 32'h1234_5678;
    reg_write = 1'b1; reg_read = 1'b1;
    tick();
    reg_write = 1'b0; reg_read = 1'b0;
    check("rbw_old", {96'd0, reg_rddata}, '0);
    rd(8'd8, rv);
    check("rbw_new", {96'd0, rv}, 128'h1234_5678);
    rd(8'd200, rv);
    check("unmapped_rd", {96'd0, rv}, '0);

    // Randomized traffic against the model
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      w = ($urandom_range(0, 2) == 0);
      r = $urandom_range(0, 1);
      f = ($urandom_range(0, 5) == 0);
      a = ($urandom_range(0, 9) == 0) ? 200 : $urandom_range(0, 15);
      d = (a == 12) ? 32'($urandom_range(0, 3)) : $urandom;
      reg_address = 8'(a); reg_wrdata = d;
      reg_write = w; reg_read = r; ml_finished = f;
      model_step(w, r, a, d, f);
      tick();
      reg_write = 1'b0; reg_read = 1'b0; ml_finished = 1'b0;
      check("rnd_rddata", {96'd0, reg_rddata}, {96'd0, m_rd});
      check("rnd_ctl", {126'd0, ml_start, sts_busy}, {126'd0, m_starting, (m_starting || m_running)});
      check("rnd_ax0", ax0, {m_words[3], m_words[2], m_words[1], m_words[0]});
      check("rnd_bx0", bx0, {m_words[7], m_words[6], m_words[5], m_words[4]});
      check("rnd_bx1", bx1, {m_words[11], m_words[10], m_words[9], m_words[8]});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cn_reg_slave.md
CN_REG_SLAVE -- requirements
Module: cn_reg_slave

Interface
REQ-001 SHALL have parameter REG_AW, default 8, meaning register address width.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port reg_address, input, REG_AW, word address from the host.
REQ-005 SHALL have port reg_write, input, 1, one-cycle write strobe.
REQ-006 SHALL have port reg_read, input, 1, one-cycle read strobe.
REQ-007 SHALL have port reg_wrdata, input, 32, write data.
REQ-008 SHALL have port reg_rddata, output, 32, registered read data.
REQ-009 SHALL have ports ax0, bx0, bx1, output, 128 each, seed state to the core.
REQ-010 SHALL have port ml_start, output, 1, one-cycle start pulse to the core.
REQ-011 SHALL have port ml_finished, input, 1, completion level/pulse from the core.
REQ-012 SHALL have port sts_busy, output, 1, core running.

Function
REQ-013 SHALL map addresses 0-3 to ax0[31:0]..ax0[127:96], 4-7 to bx0 words, 8-11 to bx1 words, little-endian by word.
REQ-014 SHALL treat address 12 as CTRL: bit0 write-1 = start, bit1 write-1 = clear DONE and ERR; bits read 0.
REQ-015 SHALL treat address 13 as STATUS (read-only): bit0 busy, bit1 done, bit2 err.
REQ-016 SHALL keep FSM states IDLE, START, BUSY, DONE.
REQ-017 SHALL go IDLE/DONE -> START on CTRL bit0 write; START -> BUSY next cycle; BUSY -> DONE on first cycle ml_finished=1; DONE -> IDLE on CTRL bit1 write without bit0.
REQ-018 SHALL assert ml_start for exactly the one cycle in START; sts_busy high in START and BUSY.
REQ-019 SHALL ignore writes to addresses 0-11 and CTRL bit0 while in START/BUSY, and set sticky ERR for each such write.
REQ-020 SHALL, on CTRL write with bit0 and bit1 both set from DONE, clear DONE/ERR and enter START.
REQ-021 SHALL return read data on reg_rddata exactly one cycle after reg_read; holds value otherwise.
REQ-022 SHALL return 0 for reads of unmapped addresses; writes to unmapped or STATUS addresses have no effect and do not set ERR.
REQ-023 SHALL give read-before-write ordering when reg_read and reg_write hit the same address in one cycle (old value returned).
REQ-024 SHALL ignore ml_finished outside BUSY.

Reset
REQ-025 SHALL on reset clear ax0, bx0, bx1, reg_rddata, ERR to 0, ml_start and sts_busy to 0, FSM to IDLE.
REQ-026 SHALL abandon any run when reset asserts mid-BUSY; no ml_start issued after reset releases until a new CTRL write.

Configuration
REQ-027 SHALL, with CN_REG_CYCLE_CNT_EN defined, implement read-only address 14 = 32-bit count of cycles spent in BUSY for the last/current run, cleared on entry to START, saturating at 0xFFFFFFFF.
REQ-028 SHALL, without CN_REG_CYCLE_CNT_EN, contain no counter logic and read address 14 as 0.

Structure
REQ-029 SHALL take address constants (ADDR_AX0..ADDR_CYCLES), CTRL/STATUS bit indices and the FSM state enum from shared package cn_reg_pkg.
REQ-030 SHALL place the FSM and cycle counter in sub-module cn_reg_ctrl_fsm; register file and read mux stay in cn_reg_slave.

Verification
REQ-031 SHALL cover: write 0x61833732 to addr 0 and 0x88622535 to addr 1, read both -> ax0[63:0]=0x8862253561833732, readback matches after 1 cycle.
REQ-032 SHALL cover: write CTRL=1 -> ml_start high exactly 1 cycle, STATUS=0x1 until ml_finished pulse, then STATUS=0x2.
REQ-033 SHALL cover: write addr 5 = 0xDEADBEEF while BUSY -> bx0 unchanged, STATUS bit2=1; CTRL=2 after DONE -> STATUS=0.
REQ-034 SHALL cover: reset asserted 3 cycles into BUSY -> all outputs 0, STATUS=0, ml_finished afterwards leaves STATUS=0.
REQ-035 SHALL cover: with CN_REG_CYCLE_CNT_EN, ml_finished 100 cycles after ml_start -> addr 14 reads 100 (+/-0 per FSM definition: counted BUSY cycles); without macro reads 0.
REQ-036 SHALL cover: simultaneous read and write of addr 8 (old 0, new 0x12345678) -> rddata 0, next read 0x12345678; read addr 200 -> 0.
